// File: rtl/data_table_dispatch.sv
// Single-issue scheduler for the linked-list data table: decodes a task, grants one engine
// exclusive data-RAM access, forwards its result, then idles the RAM for the read latency.
package data_table_pkg;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int KEY_WIDTH        = 16;
  localparam int VALUE_WIDTH      = 16;

  localparam logic [2:0] OP_SEARCH = 3'd1;
  localparam logic [2:0] OP_INSERT = 3'd2;
  localparam logic [2:0] OP_DELETE = 3'd3;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } cmd_t;

  typedef struct packed {
    cmd_t                        cmd;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_valid;
  } ht_pdata_t;

  typedef struct packed {
    logic [2:0]                  opcode;
    logic [1:0]                  rescode;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] bucket;
  } ht_result_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_valid;
  } ram_data_t;
endpackage

module data_table_dispatch
  import data_table_pkg::*;
#(
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int RAM_LATENCY = 2,
  parameter int WDOG_CYCLES = 4096,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  ht_pdata_t                      task_i,
  input  logic                           task_valid_i,
  output logic                           task_ready_o,
  output ht_pdata_t                      eng_task_o,
  output logic [2:0]                     eng_task_valid_o,
  input  logic [2:0]                     eng_task_ready_i,
  input  ht_result_t [2:0]               eng_result_i,
  input  logic [2:0]                     eng_result_valid_i,
  output logic [2:0]                     eng_result_ready_o,
  input  logic [2:0][A_WIDTH-1:0]        eng_rd_addr_i,
  input  logic [2:0]                     eng_rd_en_i,
  input  logic [2:0][A_WIDTH-1:0]        eng_wr_addr_i,
  input  ram_data_t [2:0]                eng_wr_data_i,
  input  logic [2:0]                     eng_wr_en_i,
  output logic [A_WIDTH-1:0]             ram_rd_addr_o,
  output logic                           ram_rd_en_o,
  output logic [A_WIDTH-1:0]             ram_wr_addr_o,
  output ram_data_t                      ram_wr_data_o,
  output logic                           ram_wr_en_o,
  output ht_result_t                     result_o,
  output logic                           result_valid_o,
  input  logic                           result_ready_i,
  output logic                           err_illegal_op_o,
  output logic                           err_access_o,
  output logic                           err_timeout_o,
  output logic [CNT_WIDTH-1:0]           done_cnt_o
);

  localparam logic [1:0] IDLE_S     = 2'd0;
  localparam logic [1:0] DISPATCH_S = 2'd1;
  localparam logic [1:0] BUSY_S     = 2'd2;
  localparam logic [1:0] GUARD_S    = 2'd3;

  localparam int GW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY + 1) : 1;
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(RAM_LATENCY);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(WDOG_CYCLES);

  logic [1:0]           state_q,    state_d;
  logic [2:0]           grant_q,    grant_d;
  ht_pdata_t            task_q,     task_d;
  logic [GW-1:0]        guard_q,    guard_d;
  logic [WW-1:0]        wdog_q,     wdog_d;
  logic                 timeout_q,  timeout_d;
  logic                 illegal_q,  illegal_d;
  logic                 access_q,   access_d;
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;

  logic [2:0] dec_grant;
  logic [1:0] sel;
  logic       active;
  logic [2:0] blocked;

  always_comb begin
    dec_grant = 3'b000;
    case (task_i.cmd.opcode)
      OP_SEARCH: dec_grant = 3'b001;
      OP_INSERT: dec_grant = 3'b010;
      OP_DELETE: dec_grant = 3'b100;
      default:   dec_grant = 3'b000;
    endcase
  end

  always_comb begin
    sel = 2'd0;
    if (grant_q[1])      sel = 2'd1;
    else if (grant_q[2]) sel = 2'd2;
  end

  // The grant owns the RAM from dispatch until the guard interval has drained.
  assign active  = (state_q != IDLE_S);
  assign blocked = (eng_rd_en_i | eng_wr_en_i) & ~(active ? grant_q : 3'b000);

  assign task_ready_o       = (state_q == IDLE_S);
  assign eng_task_o         = task_q;
  assign eng_task_valid_o   = (state_q == DISPATCH_S) ? grant_q : 3'b000;
  assign result_valid_o     = (state_q == BUSY_S) & eng_result_valid_i[sel];
  assign result_o           = (state_q == BUSY_S) ? eng_result_i[sel] : '0;
  assign eng_result_ready_o = (state_q == BUSY_S) ? (grant_q & {3{result_ready_i}}) : 3'b000;

  assign ram_rd_addr_o = active ? eng_rd_addr_i[sel] : '0;
  assign ram_rd_en_o   = active & eng_rd_en_i[sel];
  assign ram_wr_addr_o = active ? eng_wr_addr_i[sel] : '0;
  assign ram_wr_data_o = active ? eng_wr_data_i[sel] : '0;
  assign ram_wr_en_o   = active & eng_wr_en_i[sel];

  assign err_illegal_op_o = illegal_q;
  assign err_access_o     = access_q;
  assign err_timeout_o    = timeout_q;
  assign done_cnt_o       = done_cnt_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    task_d     = task_q;
    guard_d    = guard_q;
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;
    illegal_d  = 1'b0;
    access_d   = |blocked;
    done_cnt_d = done_cnt_q;

    case (state_q)
      IDLE_S: begin
        if (task_valid_i) begin
          task_d  = task_i;
          grant_d = dec_grant;
          if (|dec_grant) begin
            state_d = DISPATCH_S;
            wdog_d  = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      DISPATCH_S: begin
        if (|(eng_task_ready_i & grant_q)) state_d = BUSY_S;
      end
      BUSY_S: begin
        if (result_valid_o && result_ready_i) begin
          done_cnt_d = done_cnt_q + 1'b1;
          if (RAM_LATENCY == 0) begin
            state_d = IDLE_S;
            grant_d = 3'b000;
          end else begin
            state_d = GUARD_S;
            guard_d = GUARD_LOAD;
          end
        end
      end
      default: begin
        if (guard_q <= GW'(1)) begin
          state_d = IDLE_S;
          grant_d = 3'b000;
          guard_d = '0;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
    endcase

    // Watchdog only flags; the engine is still allowed to finish.
    if ((WDOG_CYCLES != 0) && ((state_q == DISPATCH_S) || (state_q == BUSY_S))) begin
      if (wdog_q != WDOG_LIMIT) wdog_d = wdog_q + 1'b1;
      if (wdog_d == WDOG_LIMIT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE_S;
      grant_q    <= 3'b000;
      task_q     <= '0;
      guard_q    <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
      illegal_q  <= 1'b0;
      access_q   <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      task_q     <= task_d;
      guard_q    <= guard_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
      illegal_q  <= illegal_d;
      access_q   <= access_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_data_table_dispatch.sv
// Directed bench for data_table_dispatch; the bench itself plays the three engines.
module tb_data_table_dispatch;
  import data_table_pkg::*;

  localparam int AW = TABLE_ADDR_WIDTH;

  logic                 clk;
  logic                 rst;
  ht_pdata_t            task_i;
  logic                 task_valid;
  logic                 task_ready;
  ht_pdata_t            eng_task;
  logic [2:0]           eng_task_valid;
  logic [2:0]           eng_task_ready;
  ht_result_t [2:0]     eng_result;
  logic [2:0]           eng_result_valid;
  logic [2:0]           eng_result_ready;
  logic [2:0][AW-1:0]   eng_rd_addr;
  logic [2:0]           eng_rd_en;
  logic [2:0][AW-1:0]   eng_wr_addr;
  ram_data_t [2:0]      eng_wr_data;
  logic [2:0]           eng_wr_en;
  logic [AW-1:0]        ram_rd_addr;
  logic                 ram_rd_en;
  logic [AW-1:0]        ram_wr_addr;
  ram_data_t            ram_wr_data;
  logic                 ram_wr_en;
  ht_result_t           result;
  logic                 result_valid;
  logic                 result_ready;
  logic                 err_illegal;
  logic                 err_access;
  logic                 err_timeout;
  logic [3:0]           done_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  data_table_dispatch #(
    .A_WIDTH(AW), .RAM_LATENCY(2), .WDOG_CYCLES(16), .CNT_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .task_i(task_i), .task_valid_i(task_valid), .task_ready_o(task_ready),
    .eng_task_o(eng_task), .eng_task_valid_o(eng_task_valid), .eng_task_ready_i(eng_task_ready),
    .eng_result_i(eng_result), .eng_result_valid_i(eng_result_valid),
    .eng_result_ready_o(eng_result_ready),
    .eng_rd_addr_i(eng_rd_addr), .eng_rd_en_i(eng_rd_en),
    .eng_wr_addr_i(eng_wr_addr), .eng_wr_data_i(eng_wr_data), .eng_wr_en_i(eng_wr_en),
    .ram_rd_addr_o(ram_rd_addr), .ram_rd_en_o(ram_rd_en),
    .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data), .ram_wr_en_o(ram_wr_en),
    .result_o(result), .result_valid_o(result_valid), .result_ready_i(result_ready),
    .err_illegal_op_o(err_illegal), .err_access_o(err_access), .err_timeout_o(err_timeout),
    .done_cnt_o(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic ht_pdata_t mk_task(input logic [2:0] op, input logic [AW-1:0] head);
    ht_pdata_t t;
    t = '0;
    t.cmd.opcode = op;
    t.cmd.key    = 16'hBEEF;
    t.cmd.value  = 16'h1234;
    t.head_ptr   = head;
    t.head_valid = 1'b1;
    return t;
  endfunction

  function automatic ht_result_t mk_res(input logic [2:0] op, input logic [15:0] val);
    ht_result_t r;
    r.opcode  = op;
    r.rescode = 2'b01;
    r.value   = val;
    r.bucket  = 8'h0;
    return r;
  endfunction

  task automatic do_search();
    cyc();
    task_i = mk_task(OP_SEARCH, 8'd1);
    task_valid = 1'b1;
    cyc();
    task_valid = 1'b0;
    eng_task_ready = 3'b001;
    cyc();
    eng_task_ready = 3'b000;
    eng_result[0] = mk_res(OP_SEARCH, 16'h0001);
    eng_result_valid = 3'b001;
    result_ready = 1'b1;
    cyc();
    eng_result_valid = 3'b000;
    result_ready = 1'b0;
    cyc();
    cyc();
  endtask

  ht_result_t r1, r2, r3;

  initial begin
    rst = 1'b1;
    task_i = '0; task_valid = 1'b0;
    eng_task_ready = '0; eng_result = '0; eng_result_valid = '0;
    eng_rd_addr = '0; eng_rd_en = '0; eng_wr_addr = '0; eng_wr_data = '0; eng_wr_en = '0;
    result_ready = 1'b0;
    r1 = mk_res(OP_SEARCH, 16'hA5A5);
    r2 = mk_res(OP_INSERT, 16'h5A5A);
    r3 = mk_res(OP_DELETE, 16'h0F0F);

    // Reset state
    #3;
    chk("rst_task_ready", 64'(task_ready), 64'd1);
    chk("rst_eng_valid", 64'(eng_task_valid), 64'd0);
    chk("rst_ram_rd_en", 64'(ram_rd_en), 64'd0);
    chk("rst_ram_wr_en", 64'(ram_wr_en), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_timeout", 64'(err_timeout), 64'd0);
    chk("rst_res_valid", 64'(result_valid), 64'd0);
    chk("rst_ram_addr", 64'(ram_rd_addr), 64'd0);
    cyc(); cyc();
    rst = 1'b0;

    // SEARCH, head_ptr 5
    cyc();
    task_i = mk_task(OP_SEARCH, 8'd5);
    task_valid = 1'b1;
    #1 chk("s_task_ready", 64'(task_ready), 64'd1);
    cyc();
    task_valid = 1'b0;
    eng_rd_addr[0] = 8'd5;
    eng_rd_en[0] = 1'b1;
    eng_task_ready = 3'b001;
    #1;
    chk("s_eng_valid", 64'(eng_task_valid), 64'b001);
    chk("s_head_ptr", 64'(eng_task.head_ptr), 64'd5);
    chk("s_ram_rd_addr", 64'(ram_rd_addr), 64'd5);
    chk("s_ram_rd_en", 64'(ram_rd_en), 64'd1);
    chk("s_busy_not_ready", 64'(task_ready), 64'd0);
    cyc();
    eng_rd_en = '0;
    eng_task_ready = 3'b000;
    eng_result[0] = r1;
    eng_result_valid = 3'b001;
    result_ready = 1'b1;
    #1;
    chk("s_eng_valid_drop", 64'(eng_task_valid), 64'd0);
    chk("s_res_valid", 64'(result_valid), 64'd1);
    chk("s_result", 64'(result), 64'(r1));
    chk("s_res_ready", 64'(eng_result_ready), 64'b001);
    cyc();
    eng_result_valid = 3'b000;
    result_ready = 1'b0;
    #1;
    chk("s_done_cnt", 64'(done_cnt), 64'd1);
    chk("s_guard_not_ready", 64'(task_ready), 64'd0);
    cyc();
    cyc();
    chk("s_idle_ready", 64'(task_ready), 64'd1);

    // INSERT then DELETE back-to-back, stalled result, stray write from delete engine
    cyc();
    task_i = mk_task(OP_INSERT, 8'd7);
    task_valid = 1'b1;
    cyc();
    task_i = mk_task(OP_DELETE, 8'd9);
    eng_task_ready = 3'b010;
    eng_wr_en[2] = 1'b1;
    eng_wr_addr[2] = 8'd3;
    #1;
    chk("i_eng_valid", 64'(eng_task_valid), 64'b010);
    chk("i_not_ready", 64'(task_ready), 64'd0);
    chk("i_blocked_wr", 64'(ram_wr_en), 64'd0);
    cyc();
    eng_wr_en = '0;
    eng_task_ready = 3'b000;
    eng_result[1] = r2;
    eng_result_valid = 3'b010;
    result_ready = 1'b0;
    #1;
    chk("i_access_pulse", 64'(err_access), 64'd1);
    chk("i_res_valid", 64'(result_valid), 64'd1);
    chk("i_res_ready_low", 64'(eng_result_ready), 64'd0);
    cyc();
    chk("i_access_once", 64'(err_access), 64'd0);
    cyc();
    cyc();
    result_ready = 1'b1;
    #1;
    chk("i_res_ready", 64'(eng_result_ready), 64'b010);
    chk("i_result", 64'(result), 64'(r2));
    cyc();
    eng_result_valid = 3'b000;
    result_ready = 1'b0;
    #1;
    chk("i_done_cnt", 64'(done_cnt), 64'd2);
    chk("i_guard1", 64'(task_ready), 64'd0);
    cyc();
    chk("i_guard2", 64'(task_ready), 64'd0);
    cyc();
    chk("d_ready_after_guard", 64'(task_ready), 64'd1);
    cyc();
    task_valid = 1'b0;
    eng_task_ready = 3'b100;
    #1;
    chk("d_eng_valid", 64'(eng_task_valid), 64'b100);
    chk("d_head_ptr", 64'(eng_task.head_ptr), 64'd9);
    cyc();
    eng_task_ready = 3'b000;
    eng_result[2] = r3;
    eng_result_valid = 3'b100;
    result_ready = 1'b1;
    #1 chk("d_result", 64'(result), 64'(r3));
    cyc();
    eng_result_valid = 3'b000;
    result_ready = 1'b0;
    #1 chk("d_done_cnt", 64'(done_cnt), 64'd3);
    cyc();
    cyc();

    // Illegal opcode
    cyc();
    task_i = mk_task(3'd5, 8'd2);
    task_valid = 1'b1;
    #1 chk("x_task_ready", 64'(task_ready), 64'd1);
    cyc();
    task_valid = 1'b0;
    #1;
    chk("x_illegal_pulse", 64'(err_illegal), 64'd1);
    chk("x_still_ready", 64'(task_ready), 64'd1);
    chk("x_no_eng_valid", 64'(eng_task_valid), 64'd0);
    cyc();
    chk("x_illegal_once", 64'(err_illegal), 64'd0);
    chk("x_done_cnt", 64'(done_cnt), 64'd3);

    // Watchdog: engine accepts but never answers
    cyc();
    task_i = mk_task(OP_SEARCH, 8'd4);
    task_valid = 1'b1;
    cyc();
    task_valid = 1'b0;
    #1 chk("w_entry_clear", 64'(err_timeout), 64'd0);
    cyc();
    cyc();
    eng_task_ready = 3'b001;
    cyc();
    eng_task_ready = 3'b000;
    repeat (12) cyc();
    #1 chk("w_before_limit", 64'(err_timeout), 64'd0);
    cyc();
    chk("w_at_limit", 64'(err_timeout), 64'd1);
    repeat (3) cyc();
    chk("w_sticky", 64'(err_timeout), 64'd1);
    rst = 1'b1;
    #1;
    chk("w_rst_clear", 64'(err_timeout), 64'd0);
    chk("w_rst_idle", 64'(task_ready), 64'd1);
    chk("w_rst_done", 64'(done_cnt), 64'd0);
    cyc();
    rst = 1'b0;

    // Counter wrap at 4 bits
    repeat (16) do_search();
    chk("c_wrap16", 64'(done_cnt), 64'd0);
    do_search();
    chk("c_wrap17", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_table_dispatch.md
Name: data_table_dispatch

Overview:
- Single-issue task scheduler in front of the linked-list data table.
- Decodes each incoming task's opcode and hands it to the search, insert or delete engine.
- Grants that engine exclusive use of the shared data RAM ports and passes its result back to the requester.
- Guarantees one task in flight, in-order results, and a quiet RAM between tasks.

Parameters:
A_WIDTH, TABLE_ADDR_WIDTH, data RAM address width
RAM_LATENCY, 2, data RAM read latency in cycles; sets guard interval length
WDOG_CYCLES, 4096, max cycles an engine may hold the grant before err_timeout_o is set; 0 disables
CNT_WIDTH, 32, width of done_cnt_o

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
task_i  in  ht_pdata_t  task from head-table lookup; opcode in task_i.cmd.opcode
task_valid_i  in  1  task valid
task_ready_o  out  1  scheduler can accept a task
eng_task_o  out  ht_pdata_t  latched task, broadcast to all engines
eng_task_valid_o  out  3  one-hot task valid; bit0 search, bit1 insert, bit2 delete
eng_task_ready_i  in  3  per-engine task ready
eng_result_i  in  3 x ht_result_t  per-engine result
eng_result_valid_i  in  3  per-engine result valid
eng_result_ready_o  out  3  per-engine result ready
eng_rd_addr_i  in  3 x A_WIDTH  per-engine RAM read address
eng_rd_en_i  in  3  per-engine RAM read enable
eng_wr_addr_i  in  3 x A_WIDTH  per-engine RAM write address
eng_wr_data_i  in  3 x ram_data_t  per-engine RAM write data
eng_wr_en_i  in  3  per-engine RAM write enable
ram_rd_addr_o  out  A_WIDTH  to data RAM
ram_rd_en_o  out  1  to data RAM
ram_wr_addr_o  out  A_WIDTH  to data RAM
ram_wr_data_o  out  ram_data_t  to data RAM
ram_wr_en_o  out  1  to data RAM
result_o  out  ht_result_t  forwarded result
result_valid_o  out  1  result valid
result_ready_i  in  1  downstream ready
err_illegal_op_o  out  1  one-cycle pulse: task with unknown opcode dropped
err_access_o  out  1  one-cycle pulse: non-granted engine asserted rd_en/wr_en
err_timeout_o  out  1  sticky watchdog flag
done_cnt_o  out  CNT_WIDTH  count of result handshakes

Behaviour:
- Reset (async, rst_i high):
  - state IDLE_S; grant register 0.
  - All outputs 0, except task_ready_o = 1 and ram data/address outputs = 0.
  - done_cnt_o = 0; err_timeout_o = 0; guard counter = 0.
- Opcode map: SEARCH→engine 0, INSERT→engine 1, DELETE→engine 2; any other value is illegal.
- IDLE_S:
  - task_ready_o = 1.
  - On task_valid_i & task_ready_o: latch task into eng_task_o and store a one-hot grant.
  - Legal opcode → DISPATCH_S. Illegal opcode → err_illegal_op_o pulse next cycle, task dropped, stay IDLE_S.
- DISPATCH_S:
  - eng_task_valid_o = grant (first asserted the cycle after acceptance).
  - Held stable until eng_task_ready_i[g], then → BUSY_S.
- BUSY_S:
  - result_valid_o = eng_result_valid_i[g]; result_o = eng_result_i[g]; eng_result_ready_o[g] = result_ready_i; all combinational.
  - On result_valid_o & result_ready_i: done_cnt_o increments (wraps at 2^CNT_WIDTH), → GUARD_S.
- GUARD_S:
  - Lasts exactly RAM_LATENCY cycles (counter loaded on entry) so in-flight read data is never seen by the next engine.
  - Then → IDLE_S.
- RAM mux, active in DISPATCH_S, BUSY_S and GUARD_S:
  - ram_* outputs = eng_*_i[g], purely combinational, zero added latency; engines' RAM_LATENCY assumption is preserved.
  - In IDLE_S: ram_rd_en_o = ram_wr_en_o = 0.
  - eng_rd_en_i or eng_wr_en_i from a non-granted engine (or any engine in IDLE_S) is blocked; err_access_o pulses next cycle.
- Only the granted engine ever sees eng_task_valid_o or eng_result_ready_o high; all other bits are 0.
- Watchdog:
  - Counter clears on DISPATCH_S entry and counts in DISPATCH_S and BUSY_S.
  - Reaching WDOG_CYCLES sets err_timeout_o (sticky until reset). The FSM does not abort and keeps waiting.
- Result valid dropped by engine before handshake: forwarded as-is; no state change.
- Reset mid-task: all state discarded, no result emitted; engines are reset by the same rst_i.

Test Plan:
- SEARCH task (opcode SEARCH, head_ptr 5) accepted at cycle T → eng_task_valid_o = 3'b001 at T+1; engine reads addr 5 appear on ram_rd_addr_o the same cycle; result forwarded; done_cnt_o = 1.
- INSERT then DELETE back-to-back, result_ready_i low for 3 cycles on the first → second task not accepted until 1 + RAM_LATENCY(=2) cycles after the first result handshake; results in order; done_cnt_o = 2.
- Delete engine asserts eng_wr_en_i while insert is granted → ram_wr_en_o stays 0; err_access_o pulses once.
- Illegal opcode task → task_ready_o stays 1; no eng_task_valid_o; err_illegal_op_o single pulse; done_cnt_o unchanged.
- WDOG_CYCLES = 16, engine never returns a result → err_timeout_o rises 16 cycles after DISPATCH_S entry and stays high; reset clears it and returns to IDLE_S.
- done_cnt_o with CNT_WIDTH = 4 after 17 tasks → reads 1 (wrap).
